// File: rtl/iob_2p_assim_fifo_ctrl.sv
// Width-converting FIFO controller for an asymmetric two-port memory:
// wide words are pushed on the write port, narrow slices are popped on the read port.
module iob_2p_assim_fifo_ctrl #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 16,
    parameter int W_ADDR_W = 11,
    parameter int RATIO    = W_DATA_W / R_DATA_W,
    parameter int R_ADDR_W = W_ADDR_W + $clog2(RATIO)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_valid,
    output logic                r_empty,
    output logic [R_ADDR_W:0]   level,
    output logic                overflow,
    output logic                underflow,
    output logic                mem_w_en,
    output logic [W_ADDR_W-1:0] mem_w_addr,
    output logic [W_DATA_W-1:0] mem_data_in,
    output logic                mem_r_en,
    output logic [R_ADDR_W-1:0] mem_r_addr,
    input  logic [R_DATA_W-1:0] mem_data_out
);

    localparam int LVL_W = R_ADDR_W + 1;
    localparam logic [LVL_W-1:0] CAP_L   = {1'b1, {R_ADDR_W{1'b0}}};
    localparam logic [LVL_W-1:0] RATIO_L = LVL_W'(RATIO);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam logic [LVL_W-1:0] FULL_TH = CAP_L - RATIO_L;

    logic [W_ADDR_W-1:0] wptr_q, wptr_d;
    logic [R_ADDR_W-1:0] rptr_q, rptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                r_valid_q, r_valid_d;
    logic [R_DATA_W-1:0] r_hold_q, r_hold_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                push_acc, pop_acc;

    // Handshake: a push is taken when w_en is high and w_full is low, a pop when
    // r_en is high and r_empty is low; clear blocks both. Flags come from level_q only.
    assign w_full   = (level_q > FULL_TH);
    assign r_empty  = (level_q == '0);
    assign push_acc = w_en & ~w_full & ~clear;
    assign pop_acc  = r_en & ~r_empty & ~clear;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        r_valid_d   = pop_acc;
        r_hold_d    = r_hold_q;
        overflow_d  = overflow_q | (w_en & w_full & ~clear);
        underflow_d = underflow_q | (r_en & r_empty & ~clear);

        // Memory data is only valid in the cycle r_valid is high; keep it afterwards.
        if (r_valid_q) begin
            r_hold_d = mem_data_out;
        end

        if (push_acc) begin
            wptr_d = wptr_q + W_ADDR_W'(1);
        end
        if (pop_acc) begin
            rptr_d = rptr_q + R_ADDR_W'(1);
        end

        case ({push_acc, pop_acc})
            2'b10:   level_d = level_q + RATIO_L;
            2'b01:   level_d = level_q - LVL_ONE;
            2'b11:   level_d = level_q + RATIO_L - LVL_ONE;
            default: level_d = level_q;
        endcase

        if (clear) begin
            wptr_d      = '0;
            rptr_d      = '0;
            level_d     = '0;
            r_valid_d   = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            r_valid_q   <= 1'b0;
            r_hold_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            r_valid_q   <= r_valid_d;
            r_hold_q    <= r_hold_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign r_valid     = r_valid_q;
    assign r_data      = r_valid_q ? mem_data_out : r_hold_q;
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign mem_w_en    = push_acc;
    assign mem_w_addr  = wptr_q;
    assign mem_data_in = w_data;
    assign mem_r_en    = pop_acc;
    assign mem_r_addr  = rptr_q;

endmodule
